gf_mul_serial_ctrl: RTL and testbench

//  Bit-serial GF(2^m) multiplier engine for the 16-bit SoC build. Loads operands A and B and the

---
 rtl/gf_mul_serial_ctrl_pkg.sv | 29 ++
 rtl/gf_mul_serial_ctrl_one_bit.sv | 20 ++
 rtl/gf_mul_serial_ctrl.sv | 114 +++++++++++
 tb/tb_gf_mul_serial_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gf_mul_serial_ctrl_pkg.sv
// Shared constants for the gf_mul wrappers: FSM state codes, operand select codes,
// bus width and the constant functions used to size counters and word arrays.
package gf_mul_serial_ctrl_pkg;

  localparam int BUS_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] SEL_A   = 2'd0;
  localparam logic [1:0] SEL_B   = 2'd1;
  localparam logic [1:0] SEL_G   = 2'd2;
  localparam logic [1:0] SEL_RSV = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = int'(i) + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int nwords(input int width, input int bus_w);
    return (width + bus_w - 1) / bus_w;
  endfunction

endpackage

// File: rtl/gf_mul_serial_ctrl_one_bit.sv
// One row of the bit-serial GF(2^m) multiplier: shifted partial product plus
// conditional operand add plus conditional reduction, all XOR.
module one_bit #(
  parameter int DATA_WIDTH = 163
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic                  b,
  input  logic [DATA_WIDTH-1:0] g,
  input  logic                  t_i1_m1,
  input  logic [DATA_WIDTH-1:0] t_i1_j1,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic                  out_b,
  output logic [DATA_WIDTH-1:0] t_i_j
);

  assign out_a = a;
  assign out_b = b;
  assign t_i_j = t_i1_j1 ^ ({DATA_WIDTH{b}} & a) ^ ({DATA_WIDTH{t_i1_m1}} & g);

endmodule

// File: rtl/gf_mul_serial_ctrl.sv
// Bit-serial GF(2^m) multiplier engine: operands A, B and reduction polynomial G are
// loaded word by word over a narrow bus, product A*B mod (x^m + G) is read back the same way.
module gf_mul_serial_ctrl
  import gf_mul_serial_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 163,
  parameter int BUS_W      = gf_mul_serial_ctrl_pkg::BUS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [3:0]       wr_idx,
  input  logic [BUS_W-1:0] wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic [3:0]       rd_idx,
  output logic [BUS_W-1:0] rd_data
);

  localparam int NWORDS = nwords(DATA_WIDTH, BUS_W);
  localparam int PAD_W  = NWORDS * BUS_W;
  localparam int CNT_W  = clog2(DATA_WIDTH);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] a_reg, b_reg, g_reg, t_reg, r_reg;

  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] wr_mask, wr_val;
  logic [DATA_WIDTH-1:0] t_next, t_shift;
  logic [DATA_WIDTH-1:0] unused_row_a;
  logic                  unused_row_b;

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  assign wr_ok = wr_en && (state == ST_IDLE) && (32'(wr_idx) < NWORDS) && (wr_sel != SEL_RSV);

  // Word placement is done in a padded vector so the top word's bits past m-1 fall off the cast.
  assign wr_mask = DATA_WIDTH'(PAD_W'({BUS_W{1'b1}}) << (BUS_W * 32'(wr_idx)));
  assign wr_val  = DATA_WIDTH'(PAD_W'(wr_data) << (BUS_W * 32'(wr_idx)));

  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_v);
    return (old_v & ~wr_mask) | (wr_val & wr_mask);
  endfunction

  assign t_shift = {t_reg[DATA_WIDTH-2:0], 1'b0};

  one_bit #(.DATA_WIDTH(DATA_WIDTH)) row (
    .a       (a_reg),
    .b       (b_reg[cnt]),
    .g       (g_reg),
    .t_i1_m1 (t_reg[DATA_WIDTH-1]),
    .t_i1_j1 (t_shift),
    .out_a   (unused_row_a),
    .out_b   (unused_row_b),
    .t_i_j   (t_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      g_reg <= '0;
      t_reg <= '0;
      r_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_ok) begin
            case (wr_sel)
              SEL_A:   a_reg <= merge(a_reg);
              SEL_B:   b_reg <= merge(b_reg);
              SEL_G:   g_reg <= merge(g_reg);
              default: ;
            endcase
          end
          if (start) begin
            t_reg <= '0;
            cnt   <= CNT_W'(DATA_WIDTH - 1);
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          t_reg <= t_next;
          if (cnt == '0) begin
            r_reg <= t_next;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [PAD_W-1:0] r_pad;
  logic [BUS_W-1:0] rd_words [NWORDS];

  assign r_pad = PAD_W'(r_reg);

  for (genvar k = 0; k < NWORDS; k++) begin : g_rd
    assign rd_words[k] = r_pad[k*BUS_W +: BUS_W];
  end

  assign rd_data = (32'(rd_idx) < NWORDS) ? rd_words[rd_idx] : '0;

endmodule

// File: tb/tb_gf_mul_serial_ctrl.sv
// Directed bench for gf_mul_serial_ctrl: an 8-bit AES-field instance and the 163-bit build.
module tb_gf_mul_serial_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 163-bit instance
  logic        rst = 1'b1, wr_en = 1'b0, start = 1'b0;
  logic [1:0]  wr_sel = '0;
  logic [3:0]  wr_idx = '0, rd_idx = '0;
  logic [15:0] wr_data = '0;
  logic        busy, done;
  logic [15:0] rd_data;

  // 8-bit instance
  logic        s_rst = 1'b1, s_wr_en = 1'b0, s_start = 1'b0;
  logic [1:0]  s_wr_sel = '0;
  logic [3:0]  s_wr_idx = '0, s_rd_idx = '0;
  logic [15:0] s_wr_data = '0;
  logic        s_busy, s_done;
  logic [15:0] s_rd_data;

  gf_mul_serial_ctrl #(.DATA_WIDTH(163)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  gf_mul_serial_ctrl #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_sel(s_wr_sel), .wr_idx(s_wr_idx),
    .wr_data(s_wr_data), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_idx(s_rd_idx), .rd_data(s_rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [175:0] got, input logic [175:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [3:0] idx, input logic [15:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_idx = idx; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [1:0] sel, input logic [175:0] val);
    for (int k = 0; k < 11; k++) wr(sel, 4'(k), val[16*k +: 16]);
  endtask

  // Pulse start and wait for done; cyc counts clock edges from the start edge to done.
  task automatic run_mul(output int cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_product(input string tag, input logic [175:0] exp);
    for (int k = 0; k < 11; k++) begin
      rd_idx = 4'(k);
      #1;
      check($sformatf("%s_w%0d", tag, k), 176'(rd_data), 176'(exp[16*k +: 16]));
    end
  endtask

  initial begin
    int cyc;
    int ndone;
    logic [175:0] bval;
    logic [175:0] g_c9;

    g_c9 = 176'h00C9;
    bval = 176'(163'h5_A3C9_0F12_7E8B_D4C6_19F0_2B7D_E531_8AC4_6F09_B2D7);

    tick(); tick();
    rst = 1'b0; s_rst = 1'b0;
    check("reset_busy", 176'(busy), 176'(0));
    check("reset_done", 176'(done), 176'(0));
    rd_idx = 4'd0; #1;
    check("reset_rd", 176'(rd_data), 176'(0));

    // 8-bit AES field: 0x57 * 0x83 mod 0x11B = 0xC1
    s_wr_en = 1'b1;
    s_wr_sel = 2'd2; s_wr_idx = 4'd0; s_wr_data = 16'h001B; tick();
    s_wr_sel = 2'd0; s_wr_data = 16'h0057; tick();
    s_wr_sel = 2'd1; s_wr_data = 16'h0083; tick();
    s_wr_en = 1'b0;
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("aes_busy_after_start", 176'(s_busy), 176'(1));
    cyc = 1;
    while (!s_done && cyc < 50) begin tick(); cyc++; end
    check("aes_latency", 176'(cyc), 176'(9));
    check("aes_done_busy_low", 176'(s_busy), 176'(0));
    s_rd_idx = 4'd0; #1;
    check("aes_product", 176'(s_rd_data), 176'h00C1);
    tick();
    check("aes_done_one_cycle", 176'(s_done), 176'(0));

    // A = 1: product equals B
    load(2'd2, g_c9);
    load(2'd0, 176'd1);
    load(2'd1, bval);
    run_mul(cyc);
    check("id_latency", 176'(cyc), 176'(164));
    check_product("id", bval);

    // Top word bits past x^162 are discarded on write
    wr(2'd1, 4'd10, 16'hFFFF);
    run_mul(cyc);
    bval[175:160] = 16'h0007;
    check_product("topword", bval);

    // x^162 * x = x^163 = G
    load(2'd0, 176'd1 << 162);
    load(2'd1, 176'd2);
    run_mul(cyc);
    check_product("reduce", g_c9);

    // x^162 * x^2 = x*G = x^8+x^7+x^4+x
    load(2'd1, 176'd4);
    run_mul(cyc);
    check_product("reduce2", 176'h0192);

    // x^100 * x^62 = x^162, no reduction
    load(2'd0, 176'd1 << 100);
    load(2'd1, 176'd1 << 62);
    run_mul(cyc);
    check_product("noreduce", 176'd1 << 162);

    // Writes and start during RUN are ignored
    load(2'd0, 176'd1 << 162);
    load(2'd1, 176'd2);
    start = 1'b1; tick(); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 5; i++) tick();
    wr(2'd0, 4'd0, 16'h1234);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) ndone++;
      tick();
    end
    check("run_single_done", 176'(ndone), 176'(1));
    check("run_busy_idle", 176'(busy), 176'(0));
    check_product("run_ignore", g_c9);
    run_mul(cyc);
    check_product("run_rerun", g_c9);

    // Write and start on the same IDLE cycle: RUN sees the new B
    wr_en = 1'b1; wr_sel = 2'd1; wr_idx = 4'd0; wr_data = 16'h0004; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin tick(); cyc++; end
    check("same_cycle_latency", 176'(cyc), 176'(164));
    check_product("same_cycle", 176'h0192);

    // Reset on the 50th busy cycle
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i < 50; i++) tick();
    check("rst_pre_busy", 176'(busy), 176'(1));
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_busy", 176'(busy), 176'(0));
    check("rst_done", 176'(done), 176'(0));
    ndone = 0;
    for (int i = 0; i < 200; i++) begin
      if (done) ndone++;
      tick();
    end
    check("rst_no_done", 176'(ndone), 176'(0));
    for (int k = 0; k < 16; k++) begin
      rd_idx = 4'(k); #1;
      check($sformatf("rst_rd%0d", k), 176'(rd_data), 176'(0));
    end

    // Dropped writes and out-of-range reads
    load(2'd2, g_c9);
    load(2'd0, 176'd1 << 162);
    load(2'd1, 176'd4);
    run_mul(cyc);
    check_product("pre_drop", 176'h0192);
    wr(2'd3, 4'd0, 16'hFFFF);
    wr(2'd0, 4'd11, 16'hFFFF);
    wr(2'd1, 4'd15, 16'hFFFF);
    run_mul(cyc);
    check_product("post_drop", 176'h0192);
    for (int k = 11; k < 16; k++) begin
      rd_idx = 4'(k); #1;
      check($sformatf("rd_oob%0d", k), 176'(rd_data), 176'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
